// File: rtl/sequence_generator.sv
// -----------------------------------------------------------------------------
// sequence_generator
//
// Bit-serial pattern transmitter. It is the driving end of the serial-pattern
// link; the receiving end is the sequence detector. A PAT_W-bit pattern is sent
// MSB-first, one bit per clock, REPS times, with a programmable idle gap
// between repetitions. The line idles at IDLE_BIT, so a listening detector
// stays in its reset state between frames.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous, active-high reset
//   start  in   request a new burst (sampled only in IDLE)
//   abort  in   synchronous abort of the burst in progress
//   pat    in   [PAT_W-1:0] pattern, MSB first, captured on accepted start
//   reps   in   [CNT_W-1:0] repetition count, captured on accepted start
//   gap    in   [CNT_W-1:0] idle cycles between repetitions, captured on start
//   x_out  out  serial data line
//   valid  out  high while x_out carries a pattern bit
//   busy   out  high while sending or in an inter-repetition gap
//   done   out  one-cycle pulse after the last bit of a completed burst
//
// Every output is a flop; next-state logic computes the value each output
// will show in the following cycle.
// -----------------------------------------------------------------------------
module sequence_generator #(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 8,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pat,
  input  logic [CNT_W-1:0] reps,
  input  logic [CNT_W-1:0] gap,
  output logic             x_out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  // Bit counter holds 1..PAT_W: how many bits of the current repetition have
  // already been placed on x_out.
  localparam int              BC_W     = $clog2(PAT_W + 1);
  localparam logic [BC_W-1:0] BC_ONE   = BC_W'(1);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;       // captured pattern, reloaded per rep
  logic [PAT_W-1:0] shreg_q, shreg_d;   // bits still to send, MSB next
  logic [CNT_W-1:0] reps_q, reps_d;     // repetitions left, incl. current one
  logic [CNT_W-1:0] gap_q, gap_d;       // captured gap length
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Start of a repetition: source is the input pattern on an accepted start,
  // otherwise the captured copy.
  logic             load;
  logic [PAT_W-1:0] load_src;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  // NOTE: the pattern shift register is a handful of flops, not a memory, so it
  // is reset along with the control state; x_out must read IDLE_BIT
  // immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      shreg_q   <= '0;
      reps_q    <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      bit_cnt_q <= '0;
      x_q       <= IDLE_BIT;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      shreg_q   <= shreg_d;
      reps_q    <= reps_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      x_q       <= x_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that forgot
  // one would otherwise infer a latch. Output defaults are the idle values.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    shreg_d   = shreg_q;
    reps_d    = reps_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    bit_cnt_d = bit_cnt_q;
    x_d       = IDLE_BIT;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    load      = 1'b0;
    load_src  = pat_q;

    unique case (state_q)
      S_IDLE: begin
        // abort outranks start; start with zero reps only produces done.
        if (start && !abort) begin
          if (reps != '0) begin
            pat_d    = pat;
            reps_d   = reps;
            gap_d    = gap;
            load     = 1'b1;
            load_src = pat;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_cnt_q != BC_LAST) begin
          x_d       = shreg_q[PAT_W-1];
          shreg_d   = {shreg_q[PAT_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BC_ONE;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end else begin
          // Last bit of this repetition is on the line now.
          reps_d = reps_q - CNT_ONE;
          if (reps_q == CNT_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (gap_q == '0) begin
            load = 1'b1;               // back-to-back, no bubble
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q;
            busy_d    = 1'b1;
          end
        end
      end

      S_GAP: begin
        // gap_cnt counts the gap cycles still to show, including this one.
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == CNT_ONE) begin
          load = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_ONE;
          busy_d    = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // First bit of a repetition goes out now; the rest shift from shreg.
    if (load) begin
      state_d   = S_SEND;
      x_d       = load_src[PAT_W-1];
      shreg_d   = {load_src[PAT_W-2:0], 1'b0};
      bit_cnt_d = BC_ONE;
      valid_d   = 1'b1;
      busy_d    = 1'b1;
    end
  end

  assign x_out = x_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// -----------------------------------------------------------------------------
// tb_sequence_generator
//
// Self-checking bench for sequence_generator. A reference model expands each
// accepted burst into the list of per-cycle output values it should produce
// and the bench compares the DUT against that list every cycle. Directed
// scenarios add literal checks on the collected bit stream, and a small
// pattern detector on x_out exercises the loopback use.
// -----------------------------------------------------------------------------
module tb_sequence_generator;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pat;
  logic [CNT_W-1:0] reps;
  logic [CNT_W-1:0] gap;
  logic             x_out;
  logic             valid;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  sequence_generator #(
    .PAT_W   (PAT_W),
    .CNT_W   (CNT_W),
    .IDLE_BIT(1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .abort(abort),
    .pat  (pat),
    .reps (reps),
    .gap  (gap),
    .x_out(x_out),
    .valid(valid),
    .busy (busy),
    .done (done)
  );

  // Loopback partner: detector for 0111, y high the cycle after the 4th bit.
  logic [3:0] hist;
  logic       y_det;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= 4'hF;
    else     hist <= {hist[2:0], x_out};
  end
  assign y_det = (hist == 4'b0111);

  // ---------------------------------------------------------------------------
  // Reference model: list of expected per-cycle outputs
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic x;
    logic v;
    logic b;
    logic d;
  } obs_t;

  localparam obs_t IDLE_E = '{x: 1'b1, v: 1'b0, b: 1'b0, d: 1'b0};

  obs_t  exp_q[$];
  obs_t  cur;
  string phase;

  int n_checks = 0;
  int n_fail   = 0;

  // Stream statistics, cleared at the start of each directed scenario.
  logic [63:0] cap;
  int          cap_n;
  int          done_n;
  int          busy_n;
  int          y_n;
  int          vcount;
  logic        prev_last;
  logic        lb_on;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  // A burst is: reps copies of the pattern (MSB first), gap idle-but-busy
  // cycles between copies, then one done cycle.
  function automatic void build(input logic [PAT_W-1:0] p, input int n_reps,
                                input int n_gap);
    for (int r = 0; r < n_reps; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--)
        exp_q.push_back('{x: p[b], v: 1'b1, b: 1'b1, d: 1'b0});
      if (r < n_reps - 1)
        for (int g = 0; g < n_gap; g++)
          exp_q.push_back('{x: 1'b1, v: 1'b0, b: 1'b1, d: 1'b0});
    end
    exp_q.push_back('{x: 1'b1, v: 1'b0, b: 1'b0, d: 1'b1});
  endfunction

  task automatic clear_stats();
    cap       = '0;
    cap_n     = 0;
    done_n    = 0;
    busy_n    = 0;
    y_n       = 0;
    vcount    = 0;
    prev_last = 1'b0;
  endtask

  // One clock: apply start/abort, advance the model, compare after the edge.
  task automatic step(input logic st, input logic ab);
    obs_t nxt;
    start = st;
    abort = ab;
    if (cur.b && ab) begin
      exp_q.delete();
      nxt = IDLE_E;
    end else begin
      if (!cur.b && st && !ab) build(pat, int'(reps), int'(gap));
      nxt = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_E;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    cur   = nxt;
    check("x_out", x_out, cur.x);
    check("valid", valid, cur.v);
    check("busy",  busy,  cur.b);
    check("done",  done,  cur.d);
    if (valid) begin
      cap = {cap[62:0], x_out};
      cap_n++;
    end
    if (done) done_n++;
    if (busy) busy_n++;
    if (lb_on && y_det) begin
      y_n++;
      check("y_after_4th_bit", prev_last, 1'b1);
    end
    prev_last = valid && ((vcount % PAT_W) == PAT_W - 1);
    if (valid) vcount++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic setup(input logic [PAT_W-1:0] p, input int r, input int g);
    pat  = p;
    reps = CNT_W'(r);
    gap  = CNT_W'(g);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    lb_on = 1'b0;
    setup(4'b0000, 0, 0);
    cur   = IDLE_E;
    clear_stats();

    // Reset state
    phase = "reset";
    #3;
    check("x_out", x_out, 1'b1);
    check("valid", valid, 1'b0);
    check("busy",  busy,  1'b0);
    check("done",  done,  1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single frame
    phase = "single";
    setup(4'b0111, 1, 0);
    clear_stats();
    step(1'b1, 1'b0);
    idle(6);
    check("bits",   cap[3:0], 4'b0111);
    check("nbits",  cap_n,    4);
    check("ndone",  done_n,   1);
    check("nbusy",  busy_n,   4);

    // Back-to-back repetitions
    phase = "b2b";
    setup(4'b0111, 2, 0);
    clear_stats();
    step(1'b1, 1'b0);
    idle(10);
    check("bits",  cap[7:0], 8'b01110111);
    check("nbits", cap_n,    8);
    check("nbusy", busy_n,   8);
    check("ndone", done_n,   1);

    // Gap insertion
    phase = "gap";
    setup(4'b1010, 2, 3);
    clear_stats();
    step(1'b1, 1'b0);
    idle(13);
    check("bits",  cap[7:0], 8'b10101010);
    check("nbusy", busy_n,   11);
    check("ndone", done_n,   1);

    // Zero repetitions
    phase = "reps0";
    setup(4'b0110, 0, 2);
    clear_stats();
    step(1'b1, 1'b0);
    check("done_next", done, 1'b1);
    idle(3);
    check("nbits", cap_n,  0);
    check("ndone", done_n, 1);
    check("nbusy", busy_n, 0);

    // Start while busy is ignored; input changes after capture are ignored
    phase = "start_busy";
    setup(4'b0111, 1, 0);
    clear_stats();
    step(1'b1, 1'b0);
    setup(4'b1000, 5, 1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(5);
    check("bits",  cap[3:0], 4'b0111);
    check("nbits", cap_n,    4);
    check("ndone", done_n,   1);

    // Abort in GAP
    phase = "abort_gap";
    setup(4'b1100, 3, 4);
    clear_stats();
    step(1'b1, 1'b0);
    idle(5);
    check("in_gap", busy, 1'b1);
    step(1'b0, 1'b1);
    check("busy_after_abort", busy, 1'b0);
    idle(8);
    check("nbits", cap_n,  4);
    check("ndone", done_n, 0);

    // Start in the done cycle is accepted
    phase = "start_in_done";
    setup(4'b0111, 1, 0);
    clear_stats();
    step(1'b1, 1'b0);
    idle(4);
    check("done_cycle", done, 1'b1);
    setup(4'b1001, 1, 0);
    step(1'b1, 1'b0);
    idle(5);
    check("bits",  cap[7:0], 8'b01111001);
    check("ndone", done_n,   2);

    // Asynchronous reset mid-burst, then a normal frame
    phase = "reset_mid";
    setup(4'b0111, 3, 0);
    clear_stats();
    step(1'b1, 1'b0);
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    check("x_out", x_out, 1'b1);
    check("valid", valid, 1'b0);
    check("busy",  busy,  1'b0);
    check("done",  done,  1'b0);
    exp_q.delete();
    cur = IDLE_E;
    @(negedge clk);
    rst = 1'b0;
    setup(4'b0111, 1, 0);
    clear_stats();
    step(1'b1, 1'b0);
    idle(6);
    check("bits",  cap[3:0], 4'b0111);
    check("ndone", done_n,   1);

    // Loopback into a 0111 detector
    phase = "loopback";
    setup(4'b0111, 2, 2);
    clear_stats();
    lb_on = 1'b1;
    step(1'b1, 1'b0);
    idle(14);
    lb_on = 1'b0;
    check("y_pulses", y_n, 2);

    // Maximum repetition count, no wrap-around
    phase = "max_reps";
    setup(4'($urandom), 255, 0);
    clear_stats();
    step(1'b1, 1'b0);
    idle(1030);
    check("nbits", cap_n,  1020);
    check("ndone", done_n, 1);

    // Random traffic against the model
    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        setup(4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
